// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Drives the stopwatch's 4-digit, time-multiplexed 7-segment display.
// It steps through digits 0..3, each held for REFRESH_DIV clock cycles (one
// "slot"). At the start of every slot the anodes are kept off for BLANK_CYC
// cycles so that segment data settling on the new digit cannot ghost onto
// the previous one. Leading zeros can be suppressed on request.
//
// Parameters
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   BLANK_CYC    dead-time cycles at the start of each slot (< REFRESH_DIV)
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   en         in   display enable; 0 = dark, scan parked at slot 0
//   lz_blank   in   1 = blank leading-zero digits
//   digit_nz   in   [3:0] per-digit nonzero flags, bit 3 = most significant
//   dp_en      in   decimal point enable
//   dp_pos     in   [1:0] digit index carrying the decimal point
//   sel        out  [1:0] digit index for the downstream 4:1 digit mux
//   an         out  [3:0] anode enables, active-low, at most one bit low
//   dp_n       out  decimal point segment, active-low
//   slot_tick  out  one-cycle pulse in the last cycle of every slot
//
// All outputs are registered. They are decoded from the next-state values
// of the scan counter and digit index, so in any cycle they describe the
// same slot position that cnt_q/sel_q hold.
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       lz_blank,
  input  logic [3:0] digit_nz,
  input  logic       dp_en,
  input  logic [1:0] dp_pos,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       dp_n,
  output logic       slot_tick
);

  // Counter width; guarded so a degenerate parameter never yields width 0.
  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic          SKIP_BLANK = (BLANK_CYC == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      an_q, an_d;
  logic            dp_n_q, dp_n_d;
  logic            tick_q, tick_d;
  logic            digit_blank_s;

  // A digit s >= 1 is a leading zero when it and every more significant
  // digit are zero. Digit 0 is never blanked so an all-zero value shows "0".
  function automatic logic lz_blanked(input logic [1:0] s,
                                      input logic [3:0] nz,
                                      input logic       lz);
    logic upper_zero;
    upper_zero = 1'b0;
    case (s)
      2'd1:    upper_zero = (nz[3:1] == 3'b000);
      2'd2:    upper_zero = (nz[3:2] == 2'b00);
      2'd3:    upper_zero = (nz[3] == 1'b0);
      default: upper_zero = 1'b0;
    endcase
    return lz & upper_zero;
  endfunction

  // Scan sequencing: next state, counter and digit index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (!en) begin
      // Dropping enable parks the scan so it always restarts at slot 0.
      state_d = ST_OFF;
      cnt_d   = {CW{1'b0}};
      sel_d   = 2'd0;
    end else begin
      case (state_q)
        ST_OFF: begin
          cnt_d = {CW{1'b0}};
          sel_d = 2'd0;
          if (SKIP_BLANK) begin
            state_d = ST_DRIVE;
          end else begin
            state_d = ST_BLANK;
          end
        end
        ST_BLANK, ST_DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            // Slot wrap: advance digit (mod 4 by natural overflow).
            cnt_d = {CW{1'b0}};
            sel_d = sel_q + 2'd1;
            if (SKIP_BLANK) begin
              state_d = ST_DRIVE;
            end else begin
              state_d = ST_BLANK;
            end
          end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            sel_d = sel_q;
            if (cnt_d >= CNT_BLANK) begin
              state_d = ST_DRIVE;
            end else begin
              state_d = ST_BLANK;
            end
          end
        end
        default: begin
          // Unreachable encoding: recover to a safe dark state.
          state_d = ST_OFF;
          cnt_d   = {CW{1'b0}};
          sel_d   = 2'd0;
        end
      endcase
    end
  end

  // Output decode from next-state values so outputs line up with cnt/sel.
  always_comb begin
    an_d          = 4'hF;
    dp_n_d        = 1'b1;
    tick_d        = 1'b0;
    digit_blank_s = lz_blanked(sel_d, digit_nz, lz_blank);
    if ((state_d == ST_DRIVE) && !digit_blank_s) begin
      an_d = ~(4'b0001 << sel_d);
      if (dp_en && (sel_d == dp_pos)) begin
        dp_n_d = 1'b0;
      end else begin
        dp_n_d = 1'b1;
      end
    end else begin
      an_d   = 4'hF;
      dp_n_d = 1'b1;
    end
    // The tick marks every slot end, whether or not the digit was shown.
    if ((state_d != ST_OFF) && (cnt_d == CNT_LAST)) begin
      tick_d = 1'b1;
    end else begin
      tick_d = 1'b0;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OFF;
      cnt_q   <= {CW{1'b0}};
      sel_q   <= 2'd0;
      an_q    <= 4'hF;
      dp_n_q  <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      dp_n_q  <= dp_n_d;
      tick_q  <= tick_d;
    end
  end

  assign sel       = sel_q;
  assign an        = an_q;
  assign dp_n      = dp_n_q;
  assign slot_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Drives two instances from the same inputs: the nominal configuration
// (REFRESH_DIV=8, BLANK_CYC=2) and the edge configuration (REFRESH_DIV=2,
// BLANK_CYC=0). The reference model tracks only "cycles since the scan
// started" and derives slot position, digit, blanking and decimal point from
// it with plain division and modulo.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       lz_blank;
  logic [3:0] digit_nz;
  logic       dp_en;
  logic [1:0] dp_pos;

  logic [1:0] sel_a, sel_b;
  logic [3:0] an_a, an_b;
  logic       dp_n_a, dp_n_b;
  logic       tick_a, tick_b;

  int n_checks = 0;
  int n_errors = 0;

  // model state: running flag and cycles elapsed since scan start
  bit run = 1'b0;
  int t   = 0;
  logic [7:0] exp_a, exp_b;   // {sel[1:0], an[3:0], dp_n, tick}

  display_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .lz_blank(lz_blank),
    .digit_nz(digit_nz), .dp_en(dp_en), .dp_pos(dp_pos),
    .sel(sel_a), .an(an_a), .dp_n(dp_n_a), .slot_tick(tick_a)
  );

  display_scan_ctrl #(.REFRESH_DIV(2), .BLANK_CYC(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .lz_blank(lz_blank),
    .digit_nz(digit_nz), .dp_en(dp_en), .dp_pos(dp_pos),
    .sel(sel_b), .an(an_b), .dp_n(dp_n_b), .slot_tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs for a scan that has been running for tt cycles.
  function automatic logic [7:0] model_out(int r, int b, bit running, int tt,
                                           logic lz, logic [3:0] nz,
                                           logic dpe, logic [1:0] dpp);
    int cnt, s;
    bit drive, blk;
    logic [3:0] an_e;
    logic dpn_e, tk_e;
    logic [1:0] s2;
    if (!running) return {2'b00, 4'hF, 1'b1, 1'b0};
    cnt   = tt % r;
    s     = (tt / r) % 4;
    s2    = s[1:0];
    drive = (cnt >= b);
    blk   = 1'b0;
    if (lz && s > 0) begin
      blk = 1'b1;
      for (int k = s; k < 4; k++) if (nz[k]) blk = 1'b0;
    end
    an_e = 4'hF;
    if (drive && !blk) an_e[s] = 1'b0;
    dpn_e = !(drive && !blk && dpe && (dpp == s2));
    tk_e  = (cnt == r - 1);
    return {s2, an_e, dpn_e, tk_e};
  endfunction

  task automatic compare_all();
    check_eq("a_sel",  8'(sel_a),  8'(exp_a[7:6]));
    check_eq("a_an",   8'(an_a),   8'(exp_a[5:2]));
    check_eq("a_dp_n", 8'(dp_n_a), 8'(exp_a[1]));
    check_eq("a_tick", 8'(tick_a), 8'(exp_a[0]));
    check_eq("a_an_onehot", 8'($countones(~an_a) <= 1), 8'd1);
    check_eq("b_sel",  8'(sel_b),  8'(exp_b[7:6]));
    check_eq("b_an",   8'(an_b),   8'(exp_b[5:2]));
    check_eq("b_dp_n", 8'(dp_n_b), 8'(exp_b[1]));
    check_eq("b_tick", 8'(tick_b), 8'(exp_b[0]));
    check_eq("b_an_onehot", 8'($countones(~an_b) <= 1), 8'd1);
  endtask

  // One clock: model advances on the edge with the inputs seen there,
  // outputs are compared on the following falling edge.
  task automatic step();
    @(posedge clk);
    if (!reset_n || !en) begin
      run = 1'b0;
      t   = 0;
    end else if (!run) begin
      run = 1'b1;
      t   = 0;
    end else begin
      t++;
    end
    exp_a = model_out(8, 2, run, t, lz_blank, digit_nz, dp_en, dp_pos);
    exp_b = model_out(2, 0, run, t, lz_blank, digit_nz, dp_en, dp_pos);
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    reset_n  = 1'b0;
    en       = 1'b0;
    lz_blank = 1'b0;
    digit_nz = 4'b0000;
    dp_en    = 1'b0;
    dp_pos   = 2'd0;

    steps(3);
    reset_n = 1'b1;
    en      = 1'b1;

    // basic scan
    steps(40);

    // asynchronous reset in the middle of a drive phase of slot 1
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (run && ((t / 8) % 4) == 1 && (t % 8) >= 2 && (t % 8) <= 6) found = 1'b1;
      else step();
    end
    check_eq("reach_slot1_drive", 8'(found), 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_a_an",   8'(an_a),   8'hF);
    check_eq("rst_a_sel",  8'(sel_a),  8'd0);
    check_eq("rst_a_dp_n", 8'(dp_n_a), 8'd1);
    check_eq("rst_a_tick", 8'(tick_a), 8'd0);
    check_eq("rst_b_an",   8'(an_b),   8'hF);
    check_eq("rst_b_sel",  8'(sel_b),  8'd0);
    run = 1'b0;
    t   = 0;
    steps(2);
    reset_n = 1'b1;
    steps(12);

    // leading-zero blanking
    lz_blank = 1'b1;
    digit_nz = 4'b0001;
    steps(32);
    digit_nz = 4'b0100;
    steps(32);
    digit_nz = 4'b0000;
    steps(32);

    // decimal point
    lz_blank = 1'b0;
    dp_en    = 1'b1;
    dp_pos   = 2'd2;
    steps(32);
    lz_blank = 1'b1;
    digit_nz = 4'b0001;
    steps(32);

    // enable drop at slot 2, cnt 5
    lz_blank = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (run && ((t / 8) % 4) == 2 && (t % 8) == 5) found = 1'b1;
      else step();
    end
    check_eq("reach_slot2_cnt5", 8'(found), 8'd1);
    en = 1'b0;
    steps(5);
    en = 1'b1;
    steps(12);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 7) == 0) digit_nz = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) lz_blank = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) dp_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) dp_pos = 2'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
